data_memory_ctrl: RTL and testbench

Parametrised successor to the pipeline's byte-addressed, big-endian 64-bit data memory. Adds valid/ready request and response handshakes, sized accesses (byte/half/word/dword) with sign or zero extension, configurable read latency, and bounds checking with a fault response. Sits in the MEM stage; the pipeline stalls on ReqReady and RespValid.

---
 rtl/dmem_pkg.sv | 34 +++
 rtl/dmem_load_align.sv | 28 ++
 rtl/data_memory_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory controller.
// Size encodings, FSM states and byte-count helpers.
package dmem_pkg;

    localparam logic [1:0] DMEM_SIZE_B = 2'd0;
    localparam logic [1:0] DMEM_SIZE_H = 2'd1;
    localparam logic [1:0] DMEM_SIZE_W = 2'd2;
    localparam logic [1:0] DMEM_SIZE_D = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    function automatic logic [3:0] bytes_of(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

    // Left shift that moves a right-justified quantity to bits 63 down.
    function automatic logic [5:0] shamt_of(input logic [1:0] size);
        logic [5:0] s;
        s = 6'd0;
        unique case (size)
            DMEM_SIZE_B: s = 6'd56;
            DMEM_SIZE_H: s = 6'd48;
            DMEM_SIZE_W: s = 6'd32;
            DMEM_SIZE_D: s = 6'd0;
            default:     s = 6'd0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load aligner: raw big-endian bytes (byte at address in [63:56])
// in, right-justified and sign/zero-extended 64-bit word out.
// Ports: raw, size, is_signed -> data.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [63:0] raw,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [63:0] data
);

    logic [5:0]  shamt;
    logic [63:0] just;
    logic [63:0] fill;

    always_comb begin
        shamt = shamt_of(size);
        just  = raw >> shamt;
        // Bits above the quantity; empty for dword, so sign is moot there.
        fill  = ~(64'hFFFF_FFFF_FFFF_FFFF >> shamt);
        data  = just;
        if (is_signed && raw[63]) begin
            data = just | fill;
        end
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// Big-endian byte-addressed data memory with valid/ready request and
// response handshakes, sized loads/stores, read latency, bounds faults.
// Ports: Clock, Reset (sync, high); ReqValid/ReqReady, ReqWrite, ReqSize,
// ReqSigned, ReqAddr, ReqWData; RespValid/RespReady, RespRData,
// RespFault, RespWrite. Optional macro DMEM_ALIGN_CHECK_EN adds a
// misalignment fault.
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int SIZE         = 1024,
    parameter int ADDR_WIDTH   = 64,
    parameter int READ_LATENCY = 1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic                  ReqWrite,
    input  logic [1:0]            ReqSize,
    input  logic                  ReqSigned,
    input  logic [ADDR_WIDTH-1:0] ReqAddr,
    input  logic [63:0]           ReqWData,
    output logic                  RespValid,
    input  logic                  RespReady,
    output logic [63:0]           RespRData,
    output logic                  RespFault,
    output logic                  RespWrite
);

    localparam int IW = $clog2(SIZE);
    localparam int CW = $clog2(READ_LATENCY + 1);
    localparam int BW = ((ADDR_WIDTH > IW) ? ADDR_WIDTH : IW) + 1;

    logic [7:0] mem [SIZE];

    dmem_state_t state, state_nx;

    logic [CW-1:0] cnt;
    logic          accept;
    logic          done;
    logic          req_fault;
    logic [3:0]    req_bytes;
    logic [BW-1:0] lim;
    logic [63:0]   wleft;

    logic [IW-1:0] lat_addr;
    logic [1:0]    lat_size;
    logic          lat_signed;
    logic          lat_fault;

    logic [IW-1:0] rd_addr;
    logic [1:0]    rd_size;
    logic          rd_signed;
    logic [63:0]   raw;
    logic [63:0]   ld_data;

    logic [63:0]   resp_rdata;
    logic          resp_fault;
    logic          resp_write;

    assign ReqReady  = !Reset &&
                       ((state == IDLE) || ((state == RESP) && RespReady));
    assign accept    = ReqValid && ReqReady;
    assign RespValid = (state == RESP);
    assign RespRData = resp_rdata;
    assign RespFault = resp_fault;
    assign RespWrite = resp_write;

    assign done = (state == BUSY) && (cnt == CW'(READ_LATENCY - 1));

    // Bounds: fault when addr > SIZE - bytes, in a width that cannot wrap.
    always_comb begin
        req_bytes = bytes_of(ReqSize);
        lim       = BW'(SIZE) - BW'(req_bytes);
        req_fault = (BW'(ReqAddr) > lim);
`ifdef DMEM_ALIGN_CHECK_EN
        if ((ReqAddr[2:0] & 3'(req_bytes - 4'd1)) != 3'd0) begin
            req_fault = 1'b1;
        end
`endif
        wleft = ReqWData << shamt_of(ReqSize);
    end

    // In BUSY the latched request drives the read; otherwise the live one.
    always_comb begin
        rd_addr   = ReqAddr[IW-1:0];
        rd_size   = ReqSize;
        rd_signed = ReqSigned;
        if (state == BUSY) begin
            rd_addr   = lat_addr;
            rd_size   = lat_size;
            rd_signed = lat_signed;
        end
        raw = '0;
        for (int k = 0; k < 8; k++) begin
            raw[63-8*k -: 8] = mem[rd_addr + IW'(k)];
        end
    end

    dmem_load_align u_align (
        .raw       (raw),
        .size      (rd_size),
        .is_signed (rd_signed),
        .data      (ld_data)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, RESP: begin
                if (accept) begin
                    if (ReqWrite || READ_LATENCY == 1) begin
                        state_nx = RESP;
                    end else begin
                        state_nx = BUSY;
                    end
                end else if ((state == RESP) && !RespReady) begin
                    state_nx = RESP;
                end else begin
                    state_nx = IDLE;
                end
            end
            BUSY: begin
                if (done) begin
                    state_nx = RESP;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            resp_rdata <= '0;
            resp_fault <= 1'b0;
            resp_write <= 1'b0;
            cnt        <= '0;
            lat_addr   <= '0;
            lat_size   <= DMEM_SIZE_B;
            lat_signed <= 1'b0;
            lat_fault  <= 1'b0;
        end else if (accept) begin
            resp_write <= ReqWrite;
            resp_fault <= req_fault;
            lat_addr   <= ReqAddr[IW-1:0];
            lat_size   <= ReqSize;
            lat_signed <= ReqSigned;
            lat_fault  <= req_fault;
            if (ReqWrite || READ_LATENCY == 1) begin
                resp_rdata <= (ReqWrite || req_fault) ? 64'd0 : ld_data;
                cnt        <= '0;
            end else begin
                cnt <= CW'(1);
            end
        end else if (state == BUSY) begin
            if (done) begin
                resp_rdata <= lat_fault ? 64'd0 : ld_data;
                cnt        <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Storage is never cleared; a committed store survives Reset.
    always_ff @(posedge Clock) begin
        if (!Reset && accept && ReqWrite && !req_fault) begin
            for (int k = 0; k < 8; k++) begin
                if (4'(k) < req_bytes) begin
                    mem[ReqAddr[IW-1:0] + IW'(k)] <= wleft[63-8*k -: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: instance 0 has READ_LATENCY=1,
// instance 1 has READ_LATENCY=3; both SIZE=1024.
module tb_data_memory_ctrl;

    logic        clk;
    logic        rst        [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_write  [2];
    logic [1:0]  req_size   [2];
    logic        req_signed [2];
    logic [63:0] req_addr   [2];
    logic [63:0] req_wdata  [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [63:0] resp_rdata [2];
    logic        resp_fault [2];
    logic        resp_write [2];

    int total = 0;
    int bad   = 0;

    data_memory_ctrl #(.SIZE(1024), .ADDR_WIDTH(64), .READ_LATENCY(1)) u_dut0 (
        .Clock(clk), .Reset(rst[0]),
        .ReqValid(req_valid[0]), .ReqReady(req_ready[0]),
        .ReqWrite(req_write[0]), .ReqSize(req_size[0]),
        .ReqSigned(req_signed[0]), .ReqAddr(req_addr[0]),
        .ReqWData(req_wdata[0]),
        .RespValid(resp_valid[0]), .RespReady(resp_ready[0]),
        .RespRData(resp_rdata[0]), .RespFault(resp_fault[0]),
        .RespWrite(resp_write[0])
    );

    data_memory_ctrl #(.SIZE(1024), .ADDR_WIDTH(64), .READ_LATENCY(3)) u_dut1 (
        .Clock(clk), .Reset(rst[1]),
        .ReqValid(req_valid[1]), .ReqReady(req_ready[1]),
        .ReqWrite(req_write[1]), .ReqSize(req_size[1]),
        .ReqSigned(req_signed[1]), .ReqAddr(req_addr[1]),
        .ReqWData(req_wdata[1]),
        .RespValid(resp_valid[1]), .RespReady(resp_ready[1]),
        .RespRData(resp_rdata[1]), .RespFault(resp_fault[1]),
        .RespWrite(resp_write[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the consuming edge.
    task automatic do_req(input int d, input logic wr, input logic [1:0] sz,
                          input logic sg, input logic [63:0] a,
                          input logic [63:0] wd, output logic [63:0] rd,
                          output logic flt, output logic rwr, output int lat);
        int n;
        req_write[d]  = wr;
        req_size[d]   = sz;
        req_signed[d] = sg;
        req_addr[d]   = a;
        req_wdata[d]  = wd;
        req_valid[d]  = 1'b1;
        resp_ready[d] = 1'b1;
        #1;
        n = 0;
        while (!req_ready[d] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!req_ready[d]) check("accept_timeout", 64'(req_ready[d]), 64'd1);
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        lat = 1;
        while (!resp_valid[d] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!resp_valid[d]) check("resp_timeout", 64'(resp_valid[d]), 64'd1);
        rd  = resp_rdata[d];
        flt = resp_fault[d];
        rwr = resp_write[d];
        @(posedge clk);
        #1;
        resp_ready[d] = 1'b0;
    endtask

    task automatic st(input int d, input string tag, input logic [1:0] sz,
                      input logic [63:0] a, input logic [63:0] wd,
                      input logic expf);
        logic [63:0] rd;
        logic        flt, rwr;
        int          lat;
        do_req(d, 1'b1, sz, 1'b0, a, wd, rd, flt, rwr, lat);
        check({tag, "_fault"}, 64'(flt), 64'(expf));
        check({tag, "_wr"}, 64'(rwr), 64'd1);
        check({tag, "_lat"}, 64'(lat), 64'd1);
        if (expf) check({tag, "_data"}, rd, 64'd0);
    endtask

    task automatic ld(input int d, input string tag, input logic [1:0] sz,
                      input logic sg, input logic [63:0] a,
                      input logic [63:0] exp, input logic expf,
                      input int explat);
        logic [63:0] rd;
        logic        flt, rwr;
        int          lat;
        do_req(d, 1'b0, sz, sg, a, 64'd0, rd, flt, rwr, lat);
        check({tag, "_data"}, rd, exp);
        check({tag, "_fault"}, 64'(flt), 64'(expf));
        check({tag, "_wr"}, 64'(rwr), 64'd0);
        check({tag, "_lat"}, 64'(lat), 64'(explat));
    endtask

    logic [63:0] bb_data [3];

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d]        = 1'b1;
            req_valid[d]  = 1'b0;
            req_write[d]  = 1'b0;
            req_size[d]   = 2'd0;
            req_signed[d] = 1'b0;
            req_addr[d]   = 64'd0;
            req_wdata[d]  = 64'd0;
            resp_ready[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(resp_valid[0]), 64'd0);
        check("rst_ready", 64'(req_ready[0]), 64'd0);
        check("rst_rdata", resp_rdata[0], 64'd0);
        check("rst_fault", 64'(resp_fault[0]), 64'd0);
        check("rst_write", 64'(resp_write[0]), 64'd0);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        #1;
        check("idle_ready0", 64'(req_ready[0]), 64'd1);
        check("idle_ready1", 64'(req_ready[1]), 64'd1);
        @(posedge clk);
        #1;

        // Dword round trip.
        st(0, "st_d18", 2'd3, 64'h18, 64'h0FFB_EA7D_EADB_EEFF, 1'b0);
        ld(0, "ld_d18", 2'd3, 1'b0, 64'h18, 64'h0FFB_EA7D_EADB_EEFF, 1'b0, 1);

        // Byte store into a known dword, then sized loads.
        st(0, "st_d20", 2'd3, 64'h20, 64'h1122_3344_5566_7788, 1'b0);
        st(0, "st_b20", 2'd0, 64'h20, 64'hAAAA_AAAA_AAAA_AA80, 1'b0);
        ld(0, "ld_bs20", 2'd0, 1'b1, 64'h20, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1);
        ld(0, "ld_bu20", 2'd0, 1'b0, 64'h20, 64'h80, 1'b0, 1);
        ld(0, "ld_d20", 2'd3, 1'b1, 64'h20, 64'h8022_3344_5566_7788, 1'b0, 1);
        ld(0, "ld_hs22", 2'd1, 1'b1, 64'h22, 64'h3344, 1'b0, 1);
        ld(0, "ld_ws24", 2'd2, 1'b1, 64'h24, 64'h5566_7788, 1'b0, 1);
        st(0, "st_w28", 2'd2, 64'h28, 64'h1234_5678_DEAD_BEEF, 1'b0);
        ld(0, "ld_ws28", 2'd2, 1'b1, 64'h28, 64'hFFFF_FFFF_DEAD_BEEF, 1'b0, 1);
        ld(0, "ld_wu28", 2'd2, 1'b0, 64'h28, 64'h0000_0000_DEAD_BEEF, 1'b0, 1);

        // Misaligned half in bounds.
        st(0, "st_h31", 2'd1, 64'h31, 64'h0000_0000_0000_BEEF, 1'b0);
        ld(0, "ld_hu31", 2'd1, 1'b0, 64'h31, 64'hBEEF, 1'b0, 1);
        ld(0, "ld_bu32", 2'd0, 1'b0, 64'h32, 64'hEF, 1'b0, 1);

        // Bounds at the top of memory.
        st(0, "st_d3f8", 2'd3, 64'h3F8, 64'h0102_0304_0506_0708, 1'b0);
        ld(0, "ld_d3fc", 2'd3, 1'b0, 64'h3FC, 64'd0, 1'b1, 1);
        st(0, "st_d3fc", 2'd3, 64'h3FC, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        ld(0, "ld_w3fc", 2'd2, 1'b0, 64'h3FC, 64'h0506_0708, 1'b0, 1);
        ld(0, "ld_b3ff", 2'd0, 1'b0, 64'h3FF, 64'h08, 1'b0, 1);
        ld(0, "ld_b400", 2'd0, 1'b0, 64'h400, 64'd0, 1'b1, 1);
        ld(0, "ld_bmax", 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1);

        // Back-to-back store/load to 0x8, one response per cycle.
        bb_data[0] = 64'h1111_2222_3333_4444;
        bb_data[1] = 64'hA5A5_5A5A_0F0F_F0F0;
        bb_data[2] = 64'hFEDC_BA98_7654_3210;
        req_size[0]   = 2'd3;
        req_signed[0] = 1'b0;
        req_addr[0]   = 64'h8;
        req_write[0]  = 1'b1;
        req_wdata[0]  = bb_data[0];
        req_valid[0]  = 1'b1;
        resp_ready[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("bb%0d_valid", i), 64'(resp_valid[0]), 64'd1);
            check($sformatf("bb%0d_wr", i), 64'(resp_write[0]), 64'((i % 2) == 0));
            check($sformatf("bb%0d_ready", i), 64'(req_ready[0]), 64'd1);
            if (i % 2 == 1) begin
                check($sformatf("bb%0d_data", i), resp_rdata[0], bb_data[i/2]);
            end
            if (i == 5) begin
                req_valid[0] = 1'b0;
            end else begin
                req_write[0] = ((i + 1) % 2) == 0;
                req_wdata[0] = bb_data[(i + 1) / 2];
            end
        end
        @(posedge clk);
        #1;
        check("bb_end_valid", 64'(resp_valid[0]), 64'd0);
        resp_ready[0] = 1'b0;

        // Latency 3 with a stalled consumer.
        st(1, "l3_st40", 2'd3, 64'h40, 64'hCAFE_BABE_1234_5678, 1'b0);
        req_write[1]  = 1'b0;
        req_size[1]   = 2'd3;
        req_signed[1] = 1'b0;
        req_addr[1]   = 64'h40;
        req_valid[1]  = 1'b1;
        resp_ready[1] = 1'b0;
        #1;
        check("l3_acc_ready", 64'(req_ready[1]), 64'd1);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        check("l3_e1_valid", 64'(resp_valid[1]), 64'd0);
        @(posedge clk);
        #1;
        check("l3_e2_valid", 64'(resp_valid[1]), 64'd0);
        @(posedge clk);
        #1;
        check("l3_e3_valid", 64'(resp_valid[1]), 64'd1);
        check("l3_e3_data", resp_rdata[1], 64'hCAFE_BABE_1234_5678);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("l3_hold%0d_valid", i), 64'(resp_valid[1]), 64'd1);
            check($sformatf("l3_hold%0d_data", i), resp_rdata[1],
                  64'hCAFE_BABE_1234_5678);
            check($sformatf("l3_hold%0d_ready", i), 64'(req_ready[1]), 64'd0);
        end
        resp_ready[1] = 1'b1;
        #1;
        check("l3_rel_ready", 64'(req_ready[1]), 64'd1);
        @(posedge clk);
        #1;
        check("l3_rel_valid", 64'(resp_valid[1]), 64'd0);
        resp_ready[1] = 1'b0;

        ld(1, "l3_fault", 2'd3, 1'b0, 64'h3FC, 64'd0, 1'b1, 3);
        ld(1, "l3_bs43", 2'd0, 1'b1, 64'h43, 64'hFFFF_FFFF_FFFF_FFBE, 1'b0, 3);

        // Reset while the latency-3 load is in BUSY.
        req_write[1]  = 1'b0;
        req_size[1]   = 2'd3;
        req_addr[1]   = 64'h40;
        req_valid[1]  = 1'b1;
        resp_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        rst[1] = 1'b1;
        @(posedge clk);
        #1;
        rst[1] = 1'b0;
        #1;
        check("rb_valid", 64'(resp_valid[1]), 64'd0);
        check("rb_rdata", resp_rdata[1], 64'd0);
        check("rb_ready", 64'(req_ready[1]), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("rb_quiet%0d", i), 64'(resp_valid[1]), 64'd0);
        end
        ld(1, "rb_ld40", 2'd3, 1'b0, 64'h40, 64'hCAFE_BABE_1234_5678, 1'b0, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
